// File: rtl/fir_coeff_loader.sv
// Runtime coefficient loader for the 8-tap FIR: buffers a framed coefficient stream in a
// shadow bank and commits it atomically to the active bank on a FIR sample strobe.
module fir_coeff_loader #(
  parameter int N1 = 8,
  parameter int N2 = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  input  logic            coef_valid,
  output logic            coef_ready,
  input  logic [N2-1:0]   coef_data,
  input  logic            enable,
  output logic [N1*N2-1:0] coeff_bus,
  output logic            busy,
  output logic            commit_pulse,
  output logic            err_abort
);

  localparam int IW = (N1 > 1) ? $clog2(N1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N1 - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

  state_t        state, next_state;
  logic [IW-1:0] idx;
  logic [N2-1:0] shadow [N1];
  logic [N2-1:0] active [N1];
  logic          accept, restart, commit;

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    restart    = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: if (load_start) next_state = LOAD;
      LOAD: begin
        // A restart outranks a beat presented in the same cycle.
        if (load_start) restart = 1'b1;
        else if (coef_valid) begin
          accept = 1'b1;
          if (idx == LAST_IDX) next_state = PEND;
        end
      end
      PEND: begin
        // Commit wins over a simultaneous load_start.
        if (enable) begin
          commit     = 1'b1;
          next_state = IDLE;
        end else if (load_start) begin
          restart    = 1'b1;
          next_state = LOAD;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign coef_ready = (state == LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      busy         <= 1'b0;
      commit_pulse <= 1'b0;
      err_abort    <= 1'b0;
      for (int k = 0; k < N1; k++) begin
        shadow[k] <= '0;
        active[k] <= (k == 0) ? N2'(1) : '0;
      end
    end else begin
      state        <= next_state;
      busy         <= (next_state != IDLE);
      commit_pulse <= commit;
      err_abort    <= restart;
      if (restart || state == IDLE) idx <= '0;
      if (accept) begin
        shadow[idx] <= coef_data;
        idx         <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
      end
      if (restart && state == PEND) begin
        for (int k = 0; k < N1; k++) shadow[k] <= '0;
      end
      if (commit) begin
        for (int k = 0; k < N1; k++) active[k] <= shadow[k];
      end
    end
  end

  always_comb begin
    coeff_bus = '0;
    for (int k = 0; k < N1; k++) coeff_bus[k*N2 +: N2] = active[k];
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: directed frames plus randomized traffic,
// compared every cycle against a frame-level reference model.
module tb_fir_coeff_loader;

  localparam int N1 = 8;
  localparam int N2 = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            load_start = 1'b0;
  logic            coef_valid = 1'b0;
  logic            coef_ready;
  logic [N2-1:0]   coef_data = '0;
  logic            enable = 1'b0;
  logic [N1*N2-1:0] coeff_bus;
  logic            busy;
  logic            commit_pulse;
  logic            err_abort;

  int total_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;

  // Reference model: mode 0=idle 1=loading 2=waiting for commit.
  int           m_mode = 0;
  logic [N2-1:0] m_buf[$];
  logic [N2-1:0] m_active [N1];
  logic         m_commit = 1'b0;
  logic         m_abort  = 1'b0;

  always #5 clk = ~clk;

  fir_coeff_loader #(.N1(N1), .N2(N2)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .coef_valid(coef_valid),
    .coef_ready(coef_ready), .coef_data(coef_data), .enable(enable),
    .coeff_bus(coeff_bus), .busy(busy), .commit_pulse(commit_pulse),
    .err_abort(err_abort)
  );

  task automatic check(input string tag, input logic [N1*N2-1:0] obs, input logic [N1*N2-1:0] exp);
    total_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input logic r, input logic ls, input logic v,
                                     input logic [N2-1:0] d, input logic en);
    m_commit = 1'b0;
    m_abort  = 1'b0;
    if (r) begin
      m_mode = 0;
      m_buf.delete();
      for (int k = 0; k < N1; k++) m_active[k] = (k == 0) ? 8'd1 : 8'd0;
    end else begin
      case (m_mode)
        0: if (ls) begin m_mode = 1; m_buf.delete(); end
        1: begin
          if (ls) begin m_buf.delete(); m_abort = 1'b1; end
          else if (v) begin
            m_buf.push_back(d);
            if (m_buf.size() == N1) m_mode = 2;
          end
        end
        default: begin
          if (en) begin
            for (int k = 0; k < N1; k++) m_active[k] = m_buf[k];
            m_buf.delete();
            m_mode   = 0;
            m_commit = 1'b1;
          end else if (ls) begin
            m_buf.delete();
            m_mode  = 1;
            m_abort = 1'b1;
          end
        end
      endcase
    end
  endfunction

  function automatic logic [N1*N2-1:0] model_bus();
    logic [N1*N2-1:0] b;
    for (int k = 0; k < N1; k++) b[k*N2 +: N2] = m_active[k];
    return b;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".bus"},    coeff_bus,    model_bus());
    check({tag, ".ready"},  64'(coef_ready),   64'(m_mode == 1));
    check({tag, ".busy"},   64'(busy),         64'(m_mode != 0));
    check({tag, ".commit"}, 64'(commit_pulse), 64'(m_commit));
    check({tag, ".abort"},  64'(err_abort),    64'(m_abort));
  endtask

  // One clock: drive inputs, clock edge, advance the model, check just after the edge.
  task automatic step(input string tag, input logic r, input logic ls, input logic v,
                      input logic [N2-1:0] d, input logic en);
    rst = r; load_start = ls; coef_valid = v; coef_data = d; enable = en;
    @(posedge clk);
    model_step(r, ls, v, d, en);
    #1;
    check_all(tag);
  endtask

  task automatic check_tap(input string tag, input int k, input logic [N2-1:0] exp);
    check(tag, 64'(coeff_bus[k*N2 +: N2]), 64'(exp));
  endtask

  initial begin
    logic [N2-1:0] v8;
    for (int k = 0; k < N1; k++) m_active[k] = '0;

    // 1: reset then idle
    step("rst", 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("idle", 0, 0, $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1));
    check_tap("t1.tap0", 0, 8'd1);
    check_tap("t1.tap7", 7, 8'd0);

    // 2: back-to-back frame 1..8, hold, then commit
    step("t2.start", 0, 1, 0, 0, 0);
    for (int k = 0; k < N1; k++) step("t2.beat", 0, 0, 1, 8'(k + 1), 0);
    for (int i = 0; i < 3; i++) step("t2.hold", 0, 0, 1, 8'($urandom), 0);
    check_tap("t2.pend_tap0", 0, 8'd1);
    step("t2.commit", 0, 0, 0, 0, 1);
    check("t2.commit_hi", 64'(commit_pulse), 64'd1);
    for (int k = 0; k < N1; k++) check_tap("t2.tap", k, 8'(k + 1));
    step("t2.after", 0, 0, 0, 0, 0);
    check("t2.commit_lo", 64'(commit_pulse), 64'd0);

    // 3: holes between beats
    step("t3.start", 0, 1, 0, 0, 0);
    for (int k = 0; k < N1; k++) begin
      step("t3.beat", 0, 0, 1, 8'(10 * (k + 1)), 0);
      if (k < N1 - 1) step("t3.hole", 0, 0, 0, 8'($urandom), 0);
    end
    step("t3.commit", 0, 0, 0, 0, 1);
    for (int k = 0; k < N1; k++) check_tap("t3.tap", k, 8'(10 * (k + 1)));

    // 4: restart mid-frame, beat in the restart cycle is dropped, negative values
    step("t4.start", 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) step("t4.partial", 0, 0, 1, 8'($urandom), 0);
    step("t4.restart", 0, 1, 1, 8'h55, 0);
    check("t4.abort", 64'(err_abort), 64'd1);
    for (int k = 0; k < N1; k++) step("t4.beat", 0, 0, 1, 8'(k - 8), 0);
    step("t4.commit", 0, 0, 0, 0, 1);
    check_tap("t4.tap0", 0, 8'hF8);
    check_tap("t4.tap7", 7, 8'hFF);

    // 5: reset mid-frame
    step("t5.start", 0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) step("t5.beat", 0, 0, 1, 8'($urandom), 0);
    step("t5.rst", 1, 0, 1, 8'($urandom), 1);
    step("t5.idle", 0, 0, 0, 0, 1);
    check_tap("t5.tap0", 0, 8'd1);

    // 6: load_start and enable together in PEND
    step("t6.start", 0, 1, 0, 0, 0);
    for (int k = 0; k < N1; k++) step("t6.beat", 0, 0, 1, 8'($urandom), 0);
    step("t6.both", 0, 1, 0, 0, 1);
    check("t6.no_abort", 64'(err_abort), 64'd0);
    check("t6.idle", 64'(busy), 64'd0);

    // PEND abort then re-load
    step("t7.start", 0, 1, 0, 0, 0);
    for (int k = 0; k < N1; k++) step("t7.beat", 0, 0, 1, 8'($urandom), 0);
    step("t7.abort", 0, 1, 0, 0, 0);
    for (int k = 0; k < N1; k++) step("t7.beat2", 0, 0, 1, 8'($urandom), 0);
    step("t7.commit", 0, 0, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      v8 = 8'($urandom);
      step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 3) != 0), v8, ($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
